// File: rtl/shift_pkg.sv
// Shared definitions for the shift_left_by_cnt denormalizer.
//   WIDTH   : data width in bits
//   CNT_W   : shift-count width in bits
//   REM_W   : width of the remaining-shift counter (holds 0..WIDTH)
//   state_t : controller states
package shift_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int REM_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_left_by_cnt_if.sv
// Request/result bundle for shift_left_by_cnt.
//   start   : request, sampled when the block is idle or done
//   dat     : operand, captured with start
//   cnt     : requested shift count, captured with start
//   busy    : high while shifting
//   done    : one-cycle pulse, result valid
//   dat_out : result register, held until the next completion
//   ovf     : sticky "a 1 was shifted out" flag (0 unless SHIFT_OVF_EN)
// master drives the request side, slave is the shifter.
interface shift_left_by_cnt_if;
  import shift_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dat;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dat_out;
  logic             ovf;

  modport master (output start, dat, cnt,
                  input  busy, done, dat_out, ovf);
  modport slave  (input  start, dat, cnt,
                  output busy, done, dat_out, ovf);
endinterface

// File: rtl/shift_left_by_cnt.sv
// Sequential denormalizer: shifts the captured operand left one bit per
// clock for min(cnt, WIDTH) clocks, then presents the result with a
// one-cycle done pulse. Rebuilds a value from its odd residue and the
// trailing-zero count.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_left_by_cnt_if.slave (start/dat/cnt in,
//           busy/done/dat_out/ovf out)
//
// Build option: define SHIFT_OVF_EN to build the sticky overflow flag;
// without it ovf is constant 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | shifting, rem_q shifts still to go (busy=1)
// DONE  | one-cycle result-valid pulse (done=1); start accepted here too
module shift_left_by_cnt
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_left_by_cnt_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dat_out_q, dat_out_d;
  logic [REM_W-1:0] eff;
  logic             accept;

  // Counts beyond WIDTH shift everything out, so they are clamped.
  always_comb begin
    if (int'(bus.cnt) > WIDTH) eff = REM_W'(WIDTH);
    else                       eff = REM_W'(bus.cnt);
  end

  assign accept = bus.start && (state_q != SHIFT);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    rem_d     = rem_q;
    dat_out_d = dat_out_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          sh_d  = bus.dat;
          rem_d = eff;
          if (eff == '0) begin
            state_d   = DONE;
            dat_out_d = bus.dat;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        rem_d = rem_q - 1'b1;
        if (rem_q == REM_W'(1)) begin
          state_d   = DONE;
          dat_out_d = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      rem_q     <= '0;
      dat_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      dat_out_q <= dat_out_d;
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.dat_out = dat_out_q;

`ifdef SHIFT_OVF_EN
  logic ovf_q, ovf_d;

  // Cleared by each accepted request, set by any outgoing MSB of 1.
  always_comb begin
    ovf_d = ovf_q;
    if (accept)                                 ovf_d = 1'b0;
    else if (state_q == SHIFT && sh_q[WIDTH-1]) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shift_left_by_cnt.sv
module tb_shift_left_by_cnt;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] last_out;

  shift_left_by_cnt_if bus_if();

  shift_left_by_cnt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] cnt;
    logic [7:0] exp_out;
    int         exp_eff;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef SHIFT_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Issue one request from a negedge and follow it to completion.
  task automatic run_vec(input logic [7:0] d, input logic [3:0] c,
                         input logic [7:0] e_out, input int e_eff, input logic e_ovf);
    int busy_cnt;
    int done_k;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.dat   = d;
    bus_if.cnt   = c;
    @(negedge clk);
    bus_if.start = 1'b0;
    busy_cnt = 0;
    done_k   = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1 && e_eff > 0) check("dat_out_hold", {24'd0, bus_if.dat_out}, {24'd0, last_out});
      if (bus_if.done) begin
        done_k = k;
        break;
      end
      if (bus_if.busy) busy_cnt++;
      @(negedge clk);
    end
    if (done_k == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no done for dat=0x%0h cnt=%0d, expected after %0d edges", d, c, e_eff + 1);
    end else begin
      check("done_latency", done_k, e_eff + 1);
      check("busy_cycles", busy_cnt, e_eff);
      check("busy_in_done", {31'd0, bus_if.busy}, 32'd0);
      check("dat_out", {24'd0, bus_if.dat_out}, {24'd0, e_out});
      check("ovf", {31'd0, bus_if.ovf}, {31'd0, ovf_exp(e_ovf)});
      @(negedge clk);
      check("done_pulse_width", {31'd0, bus_if.done}, 32'd0);
      check("idle_busy", {31'd0, bus_if.busy}, 32'd0);
      check("dat_out_after", {24'd0, bus_if.dat_out}, {24'd0, e_out});
      check("ovf_after", {31'd0, bus_if.ovf}, {31'd0, ovf_exp(e_ovf)});
    end
    last_out = e_out;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_out = 8'h00;
    bus_if.start = 1'b0;
    bus_if.dat   = 8'h00;
    bus_if.cnt   = 4'd0;

    vecs[0]  = '{8'h05, 4'd3,  8'h28, 3, 1'b0};
    vecs[1]  = '{8'h0B, 4'd0,  8'h0B, 0, 1'b0};
    vecs[2]  = '{8'hFF, 4'd12, 8'h00, 8, 1'b1};
    vecs[3]  = '{8'hFF, 4'd8,  8'h00, 8, 1'b1};
    vecs[4]  = '{8'h81, 4'd1,  8'h02, 1, 1'b1};
    vecs[5]  = '{8'h01, 4'd7,  8'h80, 7, 1'b0};
    vecs[6]  = '{8'h01, 4'd8,  8'h00, 8, 1'b1};
    vecs[7]  = '{8'hC3, 4'd15, 8'h00, 8, 1'b1};
    vecs[8]  = '{8'h3C, 4'd2,  8'hF0, 2, 1'b0};
    vecs[9]  = '{8'h3C, 4'd3,  8'hE0, 3, 1'b1};
    vecs[10] = '{8'hA5, 4'd4,  8'h50, 4, 1'b1};
    vecs[11] = '{8'h12, 4'd9,  8'h00, 8, 1'b1};

    rst_n = 1'b0;
    #23;
    check("rst_busy",    {31'd0, bus_if.busy}, 32'd0);
    check("rst_done",    {31'd0, bus_if.done}, 32'd0);
    check("rst_dat_out", {24'd0, bus_if.dat_out}, 32'd0);
    check("rst_ovf",     {31'd0, bus_if.ovf}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i].dat, vecs[i].cnt, vecs[i].exp_out, vecs[i].exp_eff, vecs[i].exp_ovf);

    // Start during SHIFT is ignored; start in DONE is taken with no gap.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.dat = 8'h01; bus_if.cnt = 4'd2;
    @(negedge clk);
    check("b2b_busy1", {31'd0, bus_if.busy}, 32'd1);
    bus_if.dat = 8'h80; bus_if.cnt = 4'd5;
    @(negedge clk);
    check("b2b_busy2", {31'd0, bus_if.busy}, 32'd1);
    bus_if.start = 1'b0;
    @(negedge clk);
    check("b2b_done1",    {31'd0, bus_if.done}, 32'd1);
    check("b2b_dat_out1", {24'd0, bus_if.dat_out}, 32'h04);
    bus_if.start = 1'b1; bus_if.dat = 8'h03; bus_if.cnt = 4'd1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("b2b_busy3",     {31'd0, bus_if.busy}, 32'd1);
    check("b2b_done_gap",  {31'd0, bus_if.done}, 32'd0);
    check("b2b_hold",      {24'd0, bus_if.dat_out}, 32'h04);
    @(negedge clk);
    check("b2b_done2",     {31'd0, bus_if.done}, 32'd1);
    check("b2b_dat_out2",  {24'd0, bus_if.dat_out}, 32'h06);
    @(negedge clk);
    check("b2b_idle_done", {31'd0, bus_if.done}, 32'd0);
    check("b2b_idle_busy", {31'd0, bus_if.busy}, 32'd0);
    last_out = 8'h06;

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.dat = 8'h11; bus_if.cnt = 4'd6;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", {31'd0, bus_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",    {31'd0, bus_if.busy}, 32'd0);
    check("arst_done",    {31'd0, bus_if.done}, 32'd0);
    check("arst_dat_out", {24'd0, bus_if.dat_out}, 32'd0);
    check("arst_ovf",     {31'd0, bus_if.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    last_out = 8'h00;
    run_vec(8'h11, 4'd6, 8'h40, 6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
